// File: rtl/carry_accum_pkg.sv
// -----------------------------------------------------------------------------
// carry_accum_pkg
// Shared constants for the carry_accum block:
//   OP_ADD / OP_SUB : encoding of the SUB operation-select input
//   WIDTH_MIN/MAX   : legal range of the accumulator width parameter
// Optional feature macro used by the block: CARRY_ACCUM_SAT_EN.
// -----------------------------------------------------------------------------
package carry_accum_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int WIDTH_MIN = 32'd1;
    localparam int WIDTH_MAX = 32'd64;

endpackage

// File: rtl/carry_accum_carry_chain.sv
// -----------------------------------------------------------------------------
// carry_chain
// Purely combinational WIDTH-bit ripple carry built from per-bit
// propagate/generate terms.
// Ports:
//   p    in  WIDTH  per-bit propagate (x ^ y)
//   g    in  WIDTH  per-bit generate  (x & y)
//   cin  in  1      carry into bit 0
//   sum  out WIDTH  p ^ carry-in of each bit
//   cout out 1      carry out of the MSB
// -----------------------------------------------------------------------------
module carry_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry_s;

    // Ripple the carry: a propagating bit passes cin through, otherwise g decides.
    always_comb begin
        carry_s    = {(WIDTH+1){1'b0}};
        carry_s[0] = cin;
        sum        = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (p[i]) begin
                carry_s[i+1] = carry_s[i];
            end else begin
                carry_s[i+1] = g[i];
            end
            sum[i] = p[i] ^ carry_s[i];
        end
        cout = carry_s[WIDTH];
    end

endmodule

// File: rtl/carry_accum.sv
// -----------------------------------------------------------------------------
// carry_accum
// Loadable add/subtract accumulator with registered carry, terminal-count flag
// and a one-deep history register. Priority per edge: R > L > E, else hold.
// Parameters:
//   WIDTH       accumulator/operand width (1..64)
//   INIT_VALUE  power-up value of Q and QD
//   TERM_VALUE  Q value that raises TC
// Ports:
//   C   in   clock (rising edge)
//   R   in   synchronous active-high reset
//   E   in   accumulate enable
//   L   in   load strobe (beats E)
//   SUB in   0 = Q+A, 1 = Q-A
//   D   in   load value
//   A   in   addend/subtrahend
//   Q   out  accumulator
//   CO  out  carry of last accumulate (not-borrow when subtracting)
//   TC  out  Q == TERM_VALUE
//   QD  out  Q before the last accepted operation
// Optional feature: define CARRY_ACCUM_SAT_EN to saturate instead of wrapping;
// CO still reports the raw carry in that build.
// -----------------------------------------------------------------------------
module carry_accum
    import carry_accum_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] TERM_VALUE = {WIDTH{1'b1}}
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             L,
    input  logic             SUB,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic [WIDTH-1:0] QD
);

    // Power-up values only; the reset path below always forces zero.
    logic [WIDTH-1:0] q_q  = INIT_VALUE;
    logic [WIDTH-1:0] qd_q = INIT_VALUE;
    logic             co_q = 1'b0;
    logic             tc_q = (INIT_VALUE == TERM_VALUE);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qd_d;
    logic             co_d;
    logic             tc_d;

    logic [WIDTH-1:0] a_eff_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic [WIDTH-1:0] acc_s;

    // Subtraction is Q + ~A + 1, so invert the operand and feed SUB as carry-in.
    always_comb begin
        if (SUB == OP_SUB) begin
            a_eff_s = ~A;
        end else begin
            a_eff_s = A;
        end
        p_s = q_q ^ a_eff_s;
        g_s = q_q & a_eff_s;
    end

    carry_chain #(
        .WIDTH (WIDTH)
    ) u_carry_chain (
        .p    (p_s),
        .g    (g_s),
        .cin  (SUB),
        .sum  (sum_s),
        .cout (cout_s)
    );

`ifdef CARRY_ACCUM_SAT_EN
    // Clamp: add carry-out means overflow, subtract without carry means borrow.
    always_comb begin
        if ((SUB == OP_ADD) && cout_s) begin
            acc_s = {WIDTH{1'b1}};
        end else if ((SUB == OP_SUB) && !cout_s) begin
            acc_s = {WIDTH{1'b0}};
        end else begin
            acc_s = sum_s;
        end
    end
`else
    // Wrap modulo 2^WIDTH; CO carries the wrap indication.
    always_comb begin
        acc_s = sum_s;
    end
`endif

    // Next-state selection in priority order reset, load, accumulate, hold.
    always_comb begin
        q_d  = q_q;
        qd_d = qd_q;
        co_d = co_q;
        tc_d = tc_q;
        if (R) begin
            q_d  = {WIDTH{1'b0}};
            qd_d = {WIDTH{1'b0}};
            co_d = 1'b0;
            tc_d = (TERM_VALUE == {WIDTH{1'b0}});
        end else if (L) begin
            q_d  = D;
            qd_d = q_q;
            co_d = 1'b0;
            tc_d = (D == TERM_VALUE);
        end else if (E) begin
            q_d  = acc_s;
            qd_d = q_q;
            co_d = cout_s;
            tc_d = (acc_s == TERM_VALUE);
        end else begin
            q_d  = q_q;
            qd_d = qd_q;
            co_d = co_q;
            tc_d = tc_q;
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge C) begin
        q_q  <= q_d;
        qd_q <= qd_d;
        co_q <= co_d;
        tc_q <= tc_d;
    end

    assign Q  = q_q;
    assign QD = qd_q;
    assign CO = co_q;
    assign TC = tc_q;

endmodule

// File: tb/tb_carry_accum.sv
// -----------------------------------------------------------------------------
// tb_carry_accum
// Table-driven bench for carry_accum (WIDTH=8, TERM_VALUE=0x0A). Each vector
// is applied for one rising edge and all four outputs are compared just after.
// Expected values follow the build: CARRY_ACCUM_SAT_EN selects saturated results.
// -----------------------------------------------------------------------------
module tb_carry_accum;

    typedef struct {
        logic       r;
        logic       l;
        logic       e;
        logic       sub;
        logic [7:0] d;
        logic [7:0] a;
        logic [7:0] exp_q;
        logic [7:0] exp_qd;
        logic       exp_co;
        logic       exp_tc;
    } vec_t;

    logic       c   = 1'b0;
    logic       r   = 1'b0;
    logic       e   = 1'b0;
    logic       l   = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] d   = 8'h00;
    logic [7:0] a   = 8'h00;
    logic [7:0] q;
    logic       co;
    logic       tc;
    logic [7:0] qd;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    carry_accum #(
        .WIDTH      (8),
        .INIT_VALUE (8'h00),
        .TERM_VALUE (8'h0A)
    ) dut (
        .C   (c),
        .R   (r),
        .E   (e),
        .L   (l),
        .SUB (sub),
        .D   (d),
        .A   (a),
        .Q   (q),
        .CO  (co),
        .TC  (tc),
        .QD  (qd)
    );

    always #5 c = ~c;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic add(input logic r_i, input logic l_i, input logic e_i, input logic s_i,
                       input logic [7:0] d_i, input logic [7:0] a_i,
                       input logic [7:0] q_i, input logic [7:0] qd_i,
                       input logic co_i, input logic tc_i);
        vec_t v;
        v.r = r_i; v.l = l_i; v.e = e_i; v.sub = s_i; v.d = d_i; v.a = a_i;
        v.exp_q = q_i; v.exp_qd = qd_i; v.exp_co = co_i; v.exp_tc = tc_i;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] q_ovf, q_udf, q_wrap, q_last;
`ifdef CARRY_ACCUM_SAT_EN
        q_ovf  = 8'hFF;  // F0 + 20 clamps
        q_udf  = 8'h00;  // 05 - 07 clamps
        q_wrap = 8'hFF;  // FF + 01 clamps
`else
        q_ovf  = 8'h10;
        q_udf  = 8'hFE;
        q_wrap = 8'h00;
`endif
        q_last = q_wrap;  // Q - 0 leaves Q unchanged with CO=1

        //   r     l     e     sub   d      a      q       qd      co    tc
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 8'h00,  8'h00,  1'b0, 1'b0); // reset beats load
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'hF0,  8'h00,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, q_ovf,  8'hF0,  1'b1, 1'b0); // add overflow
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h05,  q_ovf,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h07, q_udf,  8'h05,  1'b0, 1'b0); // sub borrow
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h01, 8'h3C,  q_udf,  1'b0, 1'b0); // L beats E
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h3D,  8'h3C,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h3D, 8'h00,  8'h3D,  1'b1, 1'b0); // exact sub, no borrow
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 8'h08,  8'h00,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 8'h0A,  8'h08,  1'b0, 1'b1); // reaches TERM_VALUE
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h0A,  8'h08,  1'b0, 1'b1); // idle holds
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h0A,  8'h08,  1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 8'hFF, 8'h0A,  8'h08,  1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h0A, 8'h00, 8'h0A,  8'h0A,  1'b0, 1'b1); // TC from load
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00,  8'h00,  1'b0, 1'b0); // reset aborts accumulate
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00,  8'h00,  1'b0, 1'b0); // A ignored with E=0
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF,  8'h00,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, q_wrap, 8'hFF,  1'b1, 1'b0); // wrap / clamp
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, q_last, q_wrap, 1'b1, 1'b0); // Q - 0

        // Power-up values before any clock edge.
        #1;
        check("init_q",  q,  8'h00);
        check("init_qd", qd, 8'h00);
        check("init_co", {7'd0, co}, 8'h00);
        check("init_tc", {7'd0, tc}, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            r = vecs[i].r; l = vecs[i].l; e = vecs[i].e; sub = vecs[i].sub;
            d = vecs[i].d; a = vecs[i].a;
            @(posedge c);
            #1;
            check($sformatf("v%0d_q", i),  q,  vecs[i].exp_q);
            check($sformatf("v%0d_qd", i), qd, vecs[i].exp_qd);
            check($sformatf("v%0d_co", i), {7'd0, co}, {7'd0, vecs[i].exp_co});
            check($sformatf("v%0d_tc", i), {7'd0, tc}, {7'd0, vecs[i].exp_tc});
        end

        // Reset must not act between edges: load 0x77, then raise R mid-cycle.
        r = 1'b0; e = 1'b0; l = 1'b1; d = 8'h77;
        @(posedge c);
        #1;
        check("seq_load_q", q, 8'h77);
        l = 1'b0;
        @(negedge c);
        r = 1'b1;
        #2;
        check("seq_mid_reset_q", q, 8'h77);
        @(posedge c);
        #1;
        check("seq_reset_q",  q,  8'h00);
        check("seq_reset_qd", qd, 8'h00);
        r = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
